// File: rtl/imm_pkg.sv
// Shared opcode, funct3 and encoding definitions for the immediate-generation stage.
// Optional CSR decode is enabled with the RIVIERA_IMM_CSR_EN macro (see imm_extract).
package imm_pkg;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_FENCE     = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SR  = 3'b101;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_CSR  = 3'd6
   } fmt_e;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_state_e;

endpackage

// File: rtl/imm_extract.sv
// Combinational format decode, immediate build and illegal-encoding check.
// Defining RIVIERA_IMM_CSR_EN decodes SYSTEM funct3 101/110/111 as CSR with a zimm immediate.
module imm_extract
   import imm_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output fmt_e            fmt,
   output logic            illegal
);

`ifdef RIVIERA_IMM_CSR_EN
   localparam bit CSR_EN = 1'b1;
`else
   localparam bit CSR_EN = 1'b0;
`endif

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       is_shift;

   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SR);

   // NOTE: every output gets a default first so no path through the case can infer a latch.
   always_comb begin
      imm     = '0;
      fmt     = FMT_NONE;
      illegal = 1'b0;
      case (opcode)
         OPC_LOAD, OPC_JALR: begin
            fmt = FMT_I;
            imm = XLEN'($signed(instr[31:20]));
         end
         OPC_OP_IMM: begin
            fmt = FMT_I;
            if (!is_shift) begin
               imm = XLEN'($signed(instr[31:20]));
            end else if (XLEN == 64) begin
               imm = XLEN'(instr[25:20]);
            end else begin
               imm     = XLEN'(instr[24:20]);
               illegal = instr[25];
            end
         end
         OPC_OP_IMM_32: begin
            // Word-sized immediates only exist on RV64; on RV32 this opcode is unknown.
            if (XLEN == 64) begin
               fmt = FMT_I;
               if (is_shift) begin
                  imm     = XLEN'(instr[24:20]);
                  illegal = instr[25];
               end else begin
                  imm = XLEN'($signed(instr[31:20]));
               end
            end else begin
               illegal = 1'b1;
            end
         end
         OPC_STORE: begin
            fmt = FMT_S;
            imm = XLEN'($signed({instr[31:25], instr[11:7]}));
         end
         OPC_BRANCH: begin
            fmt = FMT_B;
            imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
         end
         OPC_LUI, OPC_AUIPC: begin
            fmt = FMT_U;
            imm = XLEN'($signed({instr[31:12], 12'b0}));
         end
         OPC_JAL: begin
            fmt = FMT_J;
            imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
         end
         OPC_SYSTEM: begin
            if (CSR_EN && (funct3 inside {3'b101, 3'b110, 3'b111})) begin
               fmt = FMT_CSR;
               imm = XLEN'(instr[19:15]);
            end
         end
         OPC_OP, OPC_OP_32, OPC_FENCE: begin
            fmt = FMT_NONE;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_stage.sv
// Registered immediate-generation stage with a two-entry skid buffer on a valid/ready interface.
// Optional CSR decode is controlled by RIVIERA_IMM_CSR_EN inside imm_extract.
module imm_stage
   import imm_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [31:0]     i_instr,
   input  logic            i_flush,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_imm,
   output logic [2:0]      o_fmt,
   output logic            o_illegal,
   output logic [31:0]     o_instr
);

   buf_state_e      state;
   logic [XLEN-1:0] new_imm,  main_imm,  skid_imm;
   fmt_e            new_fmt,  main_fmt,  skid_fmt;
   logic            new_ill,  main_ill,  skid_ill;
   logic [31:0]                main_instr, skid_instr;
   logic            accept, pop;

   // Decode on the input side so both entries hold finished results.
   imm_extract #(.XLEN(XLEN)) u_extract (
      .instr   (i_instr),
      .imm     (new_imm),
      .fmt     (new_fmt),
      .illegal (new_ill)
   );

   assign o_ready = (state != BUF_FULL) && !i_rst;
   assign o_valid = (state != BUF_EMPTY);
   assign accept  = i_valid && o_ready;
   assign pop     = o_valid && i_ready;

   assign o_imm     = main_imm;
   assign o_fmt     = main_fmt;
   assign o_illegal = main_ill;
   assign o_instr   = main_instr;

   // NOTE: the data registers are reset as well, because the outputs must read zero after reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= BUF_EMPTY;
         main_imm   <= '0;
         main_fmt   <= FMT_NONE;
         main_ill   <= 1'b0;
         main_instr <= '0;
         skid_imm   <= '0;
         skid_fmt   <= FMT_NONE;
         skid_ill   <= 1'b0;
         skid_instr <= '0;
      end else if (i_flush) begin
         state <= BUF_EMPTY;
      end else begin
         case (state)
            BUF_EMPTY: begin
               if (accept) begin
                  main_imm   <= new_imm;
                  main_fmt   <= new_fmt;
                  main_ill   <= new_ill;
                  main_instr <= i_instr;
                  state      <= BUF_ONE;
               end
            end
            BUF_ONE: begin
               if (accept && pop) begin
                  main_imm   <= new_imm;
                  main_fmt   <= new_fmt;
                  main_ill   <= new_ill;
                  main_instr <= i_instr;
               end else if (accept) begin
                  skid_imm   <= new_imm;
                  skid_fmt   <= new_fmt;
                  skid_ill   <= new_ill;
                  skid_instr <= i_instr;
                  state      <= BUF_FULL;
               end else if (pop) begin
                  state <= BUF_EMPTY;
               end
            end
            BUF_FULL: begin
               if (pop) begin
                  main_imm   <= skid_imm;
                  main_fmt   <= skid_fmt;
                  main_ill   <= skid_ill;
                  main_instr <= skid_instr;
                  state      <= BUF_ONE;
               end
            end
            default: state <= BUF_EMPTY;
         endcase
      end
   end

endmodule
